mcu_pwm_player: RTL
===================

// Module: mcu_pwm_player
// PURPOSE
//  Consumes the 48-bit flattened MCU word from the SPI shift stage and drives the pwm output.
//  CE frames each SPI transfer; the word is captured into the clk domain on CE's falling edge.
//  The word is decoded as {period, duty, count}; a PWM burst is generated from these fields.
//  New frames are double-buffered and take effect on a period boundary.
// PARAMETERS
//  WORD_W       48  width of mcu_word; must equal 3*FIELD_W
//  FIELD_W      16  width of each of period / duty / count
//  SYNC_STAGES  2   flops in the CE synchronizer (>=2)
// PORTS
//  clk          in   1       system clock; single clock domain
//  reset_n      in   1       synchronous, active-low reset
//  ce           in   1       async from MCU; high during transfer, falling edge = frame complete
//  mcu_word     in   WORD_W  SPI shift register (sck domain); stable while ce low and sck idle
//  pwm          out  1       registered PWM output
//  active       out  1       high while a burst is running (state RUN)
//  frame_strobe out  1       1-cycle pulse when a frame is captured
//  done         out  1       1-cycle pulse when a finite burst completes naturally
// BEHAVIOUR
//  Reset (reset_n=0 at posedge clk): pwm, active, frame_strobe, done = 0.
//   State=IDLE; sync flops=0; shadow, pending and active config = 0; pending_valid=0.
//  Capture
//   - ce passes through SYNC_STAGES flops plus one edge flop; ce_fall = prev & ~cur.
//   - Cycle after ce_fall: shadow <= mcu_word, frame_strobe=1.
//   - ce held high or toggling mid-transfer never updates shadow.
//  Decode: P=shadow[47:32] (clk cycles per period), D=shadow[31:16] (high cycles),
//   N=shadow[15:0] (periods in burst; 0 = run forever).
//  States: IDLE, RUN.
//   - IDLE + strobe, P!=0: load config, cnt=0, periods=0, go to RUN.
//     pwm first reflects (cnt<D) the next cycle.
//   - Any state + strobe, P==0: stop command. Immediately IDLE, pwm=0, pending cleared, no done.
//   - RUN + strobe, P!=0: store as pending (a newer frame overwrites an older pending one).
//   - RUN: cnt increments each cycle and wraps at P-1. At wrap, periods increments.
//   - pwm_next = (cnt < D). D>=P gives constant high; D==0 gives constant low.
//  Period boundary (cnt==P-1)
//   - pending_valid: load pending config, clear pending, cnt=0, periods=0, stay RUN.
//   - Otherwise, if N!=0 and periods==N-1: go IDLE, pwm=0, done=1.
//   - Pending load wins over burst completion in the same cycle; no done pulse in that case.
//  Strobe on the same cycle as a boundary: the new frame becomes pending first.
//   It is applied at the boundary (zero-delay forward), so it is never lost.
//  Arithmetic: counters are FIELD_W unsigned. Compare against P-1 only when P!=0. No overflow wrap.
//  reset_n low mid-burst: next edge returns everything to reset values. A captured frame is discarded.
// STRUCTURE
//  Package mcu_pwm_pkg holds:
//   - localparams for field MSB/LSB positions.
//   - typedef struct packed {period, duty, count} pwm_cfg_t.
//   - typedef enum logic {IDLE, RUN} pwm_state_t.
//  Sub-module ce_sync: parameterised synchronizer plus falling-edge detector, outputs ce_fall.
//  The FSM, counters and pending buffer live in mcu_pwm_player.
// TESTING
//  1 Frame P=10,D=3,N=2 -> pwm 3 high/7 low twice (20 cycles), then done pulse, active=0, pwm=0.
//  2 Frame P=8,D=8,N=0 -> pwm constant high, active stays 1, done never pulses over 1000 cycles.
//  3 P=10,D=5,N=0 running; send P=4,D=1,N=0 at cnt=2 -> old period completes, then 1 high/3 low.
//  4 Running; send P=0 -> pwm=0 and active=0 within capture latency + 1 cycle; no done pulse.
//  5 Burst P=6,D=2,N=1 with a new frame whose strobe lands at cnt=5 -> new config loads, no done.
//  6 Assert reset_n=0 mid-burst and with ce high -> all outputs 0.
//    After release, ce fall captures normally, exactly one frame_strobe.

Source files
------------

// File: rtl/mcu_pwm_player_pkg.sv
// Shared types for the MCU-driven PWM player: word layout, decoded config and FSM state.
package mcu_pwm_pkg;

   localparam int CFG_FIELD_W = 16;
   localparam int CFG_WORD_W  = 3 * CFG_FIELD_W;

   localparam int PERIOD_MSB = 47;
   localparam int PERIOD_LSB = 32;
   localparam int DUTY_MSB   = 31;
   localparam int DUTY_LSB   = 16;
   localparam int COUNT_MSB  = 15;
   localparam int COUNT_LSB  = 0;

   typedef logic [CFG_FIELD_W-1:0] field_t;

   localparam field_t FIELD_ZERO = field_t'(0);
   localparam field_t FIELD_ONE  = field_t'(1);

   typedef struct packed {
      field_t period;
      field_t duty;
      field_t count;
   } pwm_cfg_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } pwm_state_t;

   function automatic pwm_cfg_t decode_word(input logic [CFG_WORD_W-1:0] word);
      pwm_cfg_t cfg;
      cfg.period = word[PERIOD_MSB:PERIOD_LSB];
      cfg.duty   = word[DUTY_MSB:DUTY_LSB];
      cfg.count  = word[COUNT_MSB:COUNT_LSB];
      return cfg;
   endfunction

endpackage

// File: rtl/mcu_pwm_player_if.sv
// MCU-side bundle: SPI frame input (ce + shifted word) and the player's status/PWM outputs.
interface mcu_pwm_player_if #(
   parameter int WORD_W = 48
);
   logic              ce;
   logic [WORD_W-1:0] mcu_word;
   logic              pwm;
   logic              active;
   logic              frame_strobe;
   logic              done;

   modport master (
      output ce, mcu_word,
      input  pwm, active, frame_strobe, done
   );

   modport slave (
      input  ce, mcu_word,
      output pwm, active, frame_strobe, done
   );
endinterface

// File: rtl/mcu_pwm_player_ce_sync.sv
// Brings the asynchronous CE into the clk domain and flags its falling edge for one cycle.
module ce_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic ce,
   output logic ce_fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   edge_q, edge_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], ce};
      edge_d = sync_q[SYNC_STAGES-1];
   end

   // NOTE: flops use <= so every stage samples its pre-edge neighbour; always_comb uses =.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         edge_q <= edge_d;
      end
   end

   assign ce_fall = edge_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/mcu_pwm_player.sv
// Captures {period, duty, count} frames from the MCU on CE fall and plays them as PWM bursts,
// double-buffering frames that arrive mid-burst until the next period boundary.
module mcu_pwm_player
   import mcu_pwm_pkg::*;
#(
   parameter int WORD_W      = 48,
   parameter int FIELD_W     = 16,
   parameter int SYNC_STAGES = 2
) (
   input logic             clk,
   input logic             reset_n,
   mcu_pwm_player_if.slave bus
);

   if (WORD_W != 3 * FIELD_W || FIELD_W != CFG_FIELD_W) begin : g_param_check
      $error("mcu_pwm_player: WORD_W must be 3*FIELD_W and FIELD_W must be %0d", CFG_FIELD_W);
   end

   logic ce_fall;

   ce_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_ce_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .ce     (bus.ce),
      .ce_fall(ce_fall)
   );

   logic [WORD_W-1:0] shadow_q, shadow_d;
   logic              strobe_q, strobe_d;
   pwm_state_t        state_q, state_d;
   pwm_cfg_t          cfg_q, cfg_d;
   pwm_cfg_t          pend_q, pend_d;
   logic              pend_valid_q, pend_valid_d;
   field_t            cnt_q, cnt_d;
   field_t            periods_q, periods_d;
   logic              pwm_q, pwm_d;
   logic              done_q, done_d;

   pwm_cfg_t new_cfg;
   logic     new_is_load;
   logic     new_is_stop;
   logic     at_wrap;
   logic     last_period;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      shadow_d     = shadow_q;
      strobe_d     = ce_fall;
      state_d      = state_q;
      cfg_d        = cfg_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      cnt_d        = cnt_q;
      periods_d    = periods_q;
      done_d       = 1'b0;

      if (ce_fall) begin
         shadow_d = bus.mcu_word;
      end

      new_cfg     = decode_word(shadow_q);
      new_is_load = strobe_q && (new_cfg.period != FIELD_ZERO);
      new_is_stop = strobe_q && (new_cfg.period == FIELD_ZERO);
      at_wrap     = (cfg_q.period != FIELD_ZERO) && (cnt_q == cfg_q.period - FIELD_ONE);
      last_period = (cfg_q.count != FIELD_ZERO) && (periods_q == cfg_q.count - FIELD_ONE);

      case (state_q)
         IDLE: begin
            if (new_is_load) begin
               cfg_d     = new_cfg;
               cnt_d     = FIELD_ZERO;
               periods_d = FIELD_ZERO;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (new_is_load) begin
               pend_d       = new_cfg;
               pend_valid_d = 1'b1;
            end
            // Reads pend_*_d so a frame arriving on the boundary cycle is applied right away.
            if (at_wrap) begin
               if (pend_valid_d) begin
                  cfg_d        = pend_d;
                  pend_valid_d = 1'b0;
                  cnt_d        = FIELD_ZERO;
                  periods_d    = FIELD_ZERO;
               end else if (last_period) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  cnt_d     = FIELD_ZERO;
                  periods_d = periods_q + FIELD_ONE;
               end
            end else begin
               cnt_d = cnt_q + FIELD_ONE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (new_is_stop) begin
         state_d      = IDLE;
         pend_d       = '0;
         pend_valid_d = 1'b0;
         done_d       = 1'b0;
      end

      // Output only from the second RUN cycle on, and drop to 0 on the cycle we leave RUN.
      pwm_d = (state_q == RUN) && (state_d == RUN) && (cnt_q < cfg_q.duty);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         shadow_q     <= '0;
         strobe_q     <= 1'b0;
         state_q      <= IDLE;
         cfg_q        <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         cnt_q        <= FIELD_ZERO;
         periods_q    <= FIELD_ZERO;
         pwm_q        <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         shadow_q     <= shadow_d;
         strobe_q     <= strobe_d;
         state_q      <= state_d;
         cfg_q        <= cfg_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         cnt_q        <= cnt_d;
         periods_q    <= periods_d;
         pwm_q        <= pwm_d;
         done_q       <= done_d;
      end
   end

   assign bus.pwm          = pwm_q;
   assign bus.active       = (state_q == RUN);
   assign bus.frame_strobe = strobe_q;
   assign bus.done         = done_q;

endmodule
